// File: rtl/gadget_seq_pkg.sv
`default_nettype none
// ============================================================================
// gadget_seq_pkg : state encoding and parameter limits for gadget_rnd_seq
// Rev 1.0
// ============================================================================
package gadget_seq_pkg;

   localparam int RND_CYC_MAX = 8;
   localparam int LAT_MAX     = 63;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      FEED  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/rnd_buf.sv
`default_nettype none
// ============================================================================
// rnd_buf : RND_CYC x RND_W write-indexed randomness buffer, clear-on-read
// Rev 1.0
// ============================================================================
module rnd_buf
   import gadget_seq_pkg::*;
#(
   parameter int RND_CYC = 1,
   parameter int RND_W   = 64
)(
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_wr_en,
   input  logic [RND_W-1:0]               i_wr_data,
   input  logic                           i_clr,
   input  logic                           i_rd_en,
   input  logic [$clog2(RND_CYC_MAX)-1:0] i_rd_idx,
   output logic [RND_W-1:0]               o_rd_data,
   output logic                           o_full
);

   logic [RND_W-1:0] r_mem [RND_CYC];
   logic [3:0]       r_cnt;
   logic [RND_W-1:0] w_rd_data;

   // Full flag: the current write fills the last free entry.
   assign o_full    = i_wr_en && (r_cnt == 4'(RND_CYC - 1));
   assign o_rd_data = w_rd_data;

   always_comb begin
      w_rd_data = '0;
      for (int i = 0; i < RND_CYC; i++) begin
         if (i_rd_idx == 3'(i)) w_rd_data = r_mem[i];
      end
      // Forward a word on the cycle it is written so it can be emitted at once.
      if (i_wr_en && (r_cnt[2:0] == i_rd_idx)) w_rd_data = i_wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
         for (int i = 0; i < RND_CYC; i++) r_mem[i] <= '0;
      end else begin
         if (i_clr)        r_cnt <= '0;
         else if (i_wr_en) r_cnt <= r_cnt + 4'd1;
         for (int i = 0; i < RND_CYC; i++) begin
            if (i_wr_en && (r_cnt[2:0] == 3'(i))) r_mem[i] <= i_wr_data;
            if (i_rd_en && (i_rd_idx == 3'(i)))   r_mem[i] <= '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/gadget_rnd_seq.sv
`default_nettype none
// ============================================================================
// gadget_rnd_seq : prefetches per-run randomness and feeds a pipelined gadget.
// Optional gadget_done latency check: define GADGET_RND_SEQ_CHECK_EN.  Rev 1.0
// ============================================================================
module gadget_rnd_seq
   import gadget_seq_pkg::*;
#(
   parameter int LAT     = 4,
   parameter int RND_CYC = 1,
   parameter int RND_W   = 64
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   input  logic [RND_W-1:0] rnd_in,
   input  logic             rnd_in_valid,
   output logic             rnd_in_ready,
   output logic [RND_W-1:0] rng_0,
   output logic             active,
   output logic             gadget_en,
   input  logic             gadget_done,
   output logic             err
);

   if ((RND_CYC < 1) || (RND_CYC > RND_CYC_MAX) || (LAT < RND_CYC) || (LAT > LAT_MAX)) begin : g_bad_param
      $error("gadget_rnd_seq: illegal LAT/RND_CYC combination");
   end

   localparam logic [5:0] c_LAT_M1 = 6'(LAT - 1);
   localparam logic [5:0] c_CYC_M1 = 6'(RND_CYC - 1);
   localparam logic [5:0] c_CYC    = 6'(RND_CYC);

   state_t           r_state;
   logic [5:0]       r_cyc;
   logic             r_busy, r_done, r_ready, r_active, r_en;
   logic [RND_W-1:0] r_rng;

   logic             w_hs, w_full, w_last, w_feed_more, w_rd_en;
   logic [5:0]       w_nxt_k;
   logic [2:0]       w_rd_idx;
   logic [RND_W-1:0] w_rd_data;

   assign w_hs        = rnd_in_valid && r_ready && (r_state == FETCH);
   assign w_last      = w_hs && w_full;
   assign w_nxt_k     = r_cyc + 6'd1;
   assign w_feed_more = (r_state == FEED) && (w_nxt_k < c_CYC);
   assign w_rd_idx    = (r_state == FEED) ? w_nxt_k[2:0] : 3'd0;
   assign w_rd_en     = w_last || w_feed_more;

   rnd_buf #(
      .RND_CYC (RND_CYC),
      .RND_W   (RND_W)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_hs),
      .i_wr_data (rnd_in),
      .i_clr     (w_last),
      .i_rd_en   (w_rd_en),
      .i_rd_idx  (w_rd_idx),
      .o_rd_data (w_rd_data),
      .o_full    (w_full)
   );

   // r_cyc counts cycles since the enable cycle; it indexes FEED and times DRAIN.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_cyc    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_ready  <= 1'b0;
         r_active <= 1'b0;
         r_en     <= 1'b0;
         r_rng    <= '0;
      end else begin
         r_done <= 1'b0;
         r_en   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= FETCH;
                  r_busy  <= 1'b1;
                  r_ready <= 1'b1;
               end
            end
            FETCH: begin
               if (w_last) begin
                  r_state  <= FEED;
                  r_ready  <= 1'b0;
                  r_rng    <= w_rd_data;
                  r_active <= 1'b1;
                  r_en     <= 1'b1;
                  r_cyc    <= '0;
               end
            end
            FEED: begin
               r_cyc <= w_nxt_k;
               if (w_feed_more) begin
                  r_rng    <= w_rd_data;
                  r_active <= 1'b1;
               end else begin
                  r_rng    <= '0;
                  r_active <= 1'b0;
               end
               if (r_cyc == c_LAT_M1) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end else if (r_cyc == c_CYC_M1) begin
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               r_cyc <= w_nxt_k;
               if (r_cyc == c_LAT_M1) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy         = r_busy;
   assign done         = r_done;
   assign rnd_in_ready = r_ready;
   assign rng_0        = r_rng;
   assign active       = r_active;
   assign gadget_en    = r_en;

`ifdef GADGET_RND_SEQ_CHECK_EN
   logic r_err;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                        r_err <= 1'b0;
      else if (gadget_done != r_done)  r_err <= 1'b1;
   end
   assign err = r_err;
`else
   logic w_unused_gadget_done;
   assign w_unused_gadget_done = gadget_done;
   assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gadget_rnd_seq.sv
`default_nettype none
// ============================================================================
// tb_gadget_rnd_seq : bench for gadget_rnd_seq (RND_CYC=1/LAT=4, RND_CYC=3/LAT=3)
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_gadget_rnd_seq;

   localparam int c_W    = 32;
   localparam int c_N    = 320;
   localparam int c_RC_A = 1;
   localparam int c_LT_A = 4;
   localparam int c_RC_B = 3;
   localparam int c_LT_B = 3;

   logic           clk;
   logic           rst;
   logic           start;
   logic           rnd_valid;
   logic [c_W-1:0] rnd_data;

   logic           busy_a, done_a, ready_a, act_a, en_a, gd_a, err_a;
   logic [c_W-1:0] rng_a;
   logic           busy_b, done_b, ready_b, act_b, en_b, gd_b, err_b;
   logic [c_W-1:0] rng_b;

   logic [37:0] vec_a, vec_b;
   assign vec_a = {busy_a, done_a, ready_a, act_a, en_a, err_a, rng_a};
   assign vec_b = {busy_b, done_b, ready_b, act_b, en_b, err_b, rng_b};

   gadget_rnd_seq #(.LAT(c_LT_A), .RND_CYC(c_RC_A), .RND_W(c_W)) u_dut_a (
      .clk(clk), .rst(rst), .start(start), .busy(busy_a), .done(done_a),
      .rnd_in(rnd_data), .rnd_in_valid(rnd_valid), .rnd_in_ready(ready_a),
      .rng_0(rng_a), .active(act_a), .gadget_en(en_a), .gadget_done(gd_a), .err(err_a)
   );

   gadget_rnd_seq #(.LAT(c_LT_B), .RND_CYC(c_RC_B), .RND_W(c_W)) u_dut_b (
      .clk(clk), .rst(rst), .start(start), .busy(busy_b), .done(done_b),
      .rnd_in(rnd_data), .rnd_in_valid(rnd_valid), .rnd_in_ready(ready_b),
      .rng_0(rng_b), .active(act_b), .gadget_en(en_b), .gadget_done(gd_b), .err(err_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_err;
   int n_chk;
   int ndone_a, ndone_b;

   // Stimulus per cycle and per-DUT expected output vectors
   bit             st [c_N];
   bit             vl [c_N];
   logic [c_W-1:0] dt [c_N];
   bit             gd [2][c_N];
   logic [37:0]    ev [2][c_N];

   typedef struct {
      bit             st;
      bit             vl;
      logic [c_W-1:0] dt;
      bit             gd;
      logic [5:0]     flags;   // busy, done, ready, active, gadget_en, err
      logic [c_W-1:0] rng;
   } vec_t;
   vec_t tbl [8];

   task automatic clear_stim();
      for (int k = 0; k < c_N; k++) begin
         st[k] = 1'b0; vl[k] = 1'b0; dt[k] = '0;
      end
   endtask

   // Run-level model: each accepted start opens a fetch window, the first RND_CYC
   // valid cycles in it supply the words, then feed/done follow at fixed offsets.
   task automatic build(input int d, input int rc, input int lat, input bit early);
      bit             busy_e [c_N];
      bit             done_e [c_N];
      bit             rdy_e  [c_N];
      bit             act_e  [c_N];
      bit             en_e   [c_N];
      logic [c_W-1:0] rng_e  [c_N];
      logic [c_W-1:0] words  [8];
      int  c, t, got, e;
      bit  sticky, err_k;
      for (int k = 0; k < c_N; k++) begin
         busy_e[k] = 0; done_e[k] = 0; rdy_e[k] = 0; act_e[k] = 0; en_e[k] = 0; rng_e[k] = '0;
      end
      c = 0;
      while (c < c_N) begin
         if (!st[c]) begin
            c++;
            continue;
         end
         t = c; got = 0; e = 0;
         for (int k = t + 1; k < c_N && got < rc; k++) begin
            busy_e[k] = 1; rdy_e[k] = 1;
            if (vl[k]) begin
               words[got] = dt[k];
               got++;
               e = k + 1;
            end
         end
         if (got < rc) break;
         for (int j = 0; j < rc; j++)
            if (e + j < c_N) begin act_e[e+j] = 1; rng_e[e+j] = words[j]; end
         if (e < c_N) en_e[e] = 1;
         for (int k = e; k <= e + lat && k < c_N; k++) busy_e[k] = 1;
         if (e + lat < c_N) done_e[e+lat] = 1;
         c = e + lat + 1;
      end
      for (int k = 0; k < c_N; k++) gd[d][k] = done_e[k];
      if (early) begin
         for (int k = 1; k < c_N; k++)
            if (done_e[k]) begin gd[d][k-1] = 1; gd[d][k] = 0; break; end
      end
      sticky = 0;
      for (int k = 0; k < c_N; k++) begin
`ifdef GADGET_RND_SEQ_CHECK_EN
         err_k = sticky;
         if (gd[d][k] != done_e[k]) sticky = 1;
`else
         err_k = 0;
`endif
         ev[d][k] = {busy_e[k], done_e[k], rdy_e[k], act_e[k], en_e[k], err_k, rng_e[k]};
      end
   endtask

   task automatic chk(input string nm, input logic [37:0] act, input logic [37:0] exp_v, input int k);
      n_chk++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s cyc %0d: got flags=%b rng=%h, want flags=%b rng=%h",
                  nm, k, act[37:32], act[31:0], exp_v[37:32], exp_v[31:0]);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0; start = 0; rnd_valid = 0; rnd_data = '0; gd_a = 0; gd_b = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic run_seg(input string nm, input int abort_at);
      ndone_a = 0; ndone_b = 0;
      do_reset();
      for (int k = 0; k < c_N; k++) begin
         @(posedge clk); #1;
         start = st[k]; rnd_valid = vl[k]; rnd_data = dt[k];
         gd_a = gd[0][k]; gd_b = gd[1][k];
         @(negedge clk);
         chk({nm, "_a"}, vec_a, ev[0][k], k);
         chk({nm, "_b"}, vec_b, ev[1][k], k);
         if (done_a) ndone_a++;
         if (done_b) ndone_b++;
         if (k == abort_at) begin
            #2 rst = 1'b0;
            #1;
            chk({nm, "_abort_a"}, vec_a, 38'd0, k);
            chk({nm, "_abort_b"}, vec_b, 38'd0, k);
            break;
         end
      end
   endtask

   task automatic build_both(input bit early);
      build(0, c_RC_A, c_LT_A, early);
      build(1, c_RC_B, c_LT_B, early);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_err = 0; n_chk = 0;

      // Directed table: RND_CYC=1, LAT=4, valid held, start in cycle 0
      for (int k = 0; k < 8; k++) begin
         tbl[k].st = (k == 0); tbl[k].vl = 1'b1; tbl[k].dt = 32'hA000_0000 + 32'(k);
         tbl[k].gd = (k == 6); tbl[k].flags = 6'b100000; tbl[k].rng = '0;
      end
      tbl[0].flags = 6'b000000;
      tbl[1].flags = 6'b101000;
      tbl[2].flags = 6'b100110; tbl[2].rng = 32'hA000_0001;
      tbl[6].flags = 6'b110000;
      tbl[7].flags = 6'b000000;
      do_reset();
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         start = tbl[k].st; rnd_valid = tbl[k].vl; rnd_data = tbl[k].dt;
         gd_a = tbl[k].gd; gd_b = 1'b0;
         @(negedge clk);
         chk("table", vec_a, {tbl[k].flags, tbl[k].rng}, k);
      end

      // RND_CYC=3 with RNG valid only every third cycle
      clear_stim();
      st[0] = 1;
      for (int k = 3; k <= 9; k += 3) begin vl[k] = 1; dt[k] = 32'hC0DE_0000 + 32'(k); end
      build_both(1'b0);
      run_seg("slow_rng", -1);

      // Start pulses while busy (cycle 6 is dut_a's DONE cycle)
      clear_stim();
      st[0] = 1; st[2] = 1; st[4] = 1; st[6] = 1;
      for (int k = 0; k < c_N; k++) begin vl[k] = 1; dt[k] = 32'h5700_0000 + 32'(k); end
      build_both(1'b0);
      run_seg("busy_start", -1);
      n_chk++;
      if (ndone_a != 1 || ndone_b != 1) begin
         n_err++;
         $display("FAIL done_count: got a=%0d b=%0d, want 1 and 1", ndone_a, ndone_b);
      end

      // Reset during dut_b FEED, then a fresh run with new words
      clear_stim();
      st[0] = 1;
      for (int k = 0; k < c_N; k++) begin vl[k] = 1; dt[k] = 32'hDEAD_0000 + 32'(k); end
      build_both(1'b0);
      run_seg("abort", 5);
      clear_stim();
      st[1] = 1;
      for (int k = 0; k < c_N; k++) begin vl[k] = (k % 2 == 0); dt[k] = 32'h1234_0000 + 32'(k); end
      build_both(1'b0);
      run_seg("post_abort", -1);

      // Early gadget_done on the first of two runs
      clear_stim();
      st[0] = 1; st[30] = 1;
      for (int k = 0; k < c_N; k++) begin vl[k] = 1; dt[k] = 32'hE000_0000 + 32'(k); end
      build_both(1'b1);
      run_seg("early_gd", -1);

      // Randomized segments
      for (int s = 0; s < 3; s++) begin
         clear_stim();
         for (int k = 0; k < c_N; k++) begin
            st[k] = (k < c_N - 120) && ($urandom_range(0, 9) == 0);
            vl[k] = ($urandom_range(0, 2) != 0);
            dt[k] = $urandom;
         end
         build_both(1'b0);
         run_seg("random", -1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/gadget_rnd_seq.md
# gadget_rnd_seq

Sequencer for a masked, fully pipelined gadget that consumes fresh randomness. It accepts a start request and prefetches the gadget's per-run randomness from an RNG source over a valid/ready handshake. It then streams that randomness gap-free while asserting `active` and pulsing the gadget enable, and reports `done` when the gadget output is valid. It sits between the RNG/PRNG and a gadget, so `active` is high exactly when fresh randomness is supplied.

## Interface

Parameters:
- `LAT`, default 4: gadget latency in cycles, from the enable cycle to the output-valid cycle; legal range RND_CYC..63.
- `RND_CYC`, default 1: consecutive cycles of randomness consumed per run; legal range 1..8.
- `RND_W`, default 64: random bits per cycle.

Ports (clock and reset first):
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous active-low reset.
- `start`  in  1  run request, sampled in IDLE only.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse: gadget output valid this cycle.
- `rnd_in`  in  RND_W  RNG data.
- `rnd_in_valid`  in  1  RNG data valid.
- `rnd_in_ready`  out  1  sequencer accepts RNG data.
- `rng_0`  out  RND_W  randomness to the gadget.
- `active`  out  1  `rng_0` carries fresh randomness this cycle.
- `gadget_en`  out  1  gadget enable pulse.
- `gadget_done`  in  1  gadget's own done; used only with the check feature.
- `err`  out  1  sticky latency-mismatch flag.

## Operation

States and transitions:
- IDLE: `start` = 1 moves to FETCH.
- FETCH: `rnd_in_ready` = 1 while fewer than RND_CYC words are buffered. Each `rnd_in_valid` && `rnd_in_ready` cycle stores a word at index `cnt` and increments `cnt`. When `cnt` reaches RND_CYC, move to FEED with `cnt` cleared. The RNG may stall indefinitely.
- FEED: lasts RND_CYC cycles, with k = 0..RND_CYC-1.
  - `rng_0` = buf[k] and `active` = 1 on every FEED cycle.
  - `gadget_en` = 1 on k = 0 only.
  - Each buffer entry is zeroed once it has been emitted, so randomness is never reused.
  - After the last FEED cycle, move to DRAIN.
- DRAIN: a counter tracks cycles since the enable cycle. When it reaches LAT-1, move to DONE.
- DONE: `done` = 1 for one cycle, then return to IDLE.

Output rules:
- `busy` is 1 in every state except IDLE.
- `rng_0` = 0 and `active` = 0 outside FEED.
- `start` while busy is ignored; no queuing.
- All outputs are registered.

## Timing

- Reset (asynchronous assert, synchronous deassert upstream) sets:
  - state = IDLE, `cnt` = 0, all buffer entries = 0;
  - `busy`, `done`, `rnd_in_ready`, `active`, `gadget_en`, `err` = 0;
  - `rng_0` = 0.
- With `start` high in cycle t and RND_CYC words available back-to-back:
  - FETCH spans t+1..t+RND_CYC;
  - enable cycle e = t+RND_CYC+1;
  - `done` is high in cycle e+LAT.
- Simultaneous events:
  - An RNG handshake on the cycle the buffer becomes full is accepted.
  - `rnd_in_ready` drops the following cycle.
  - `start` in the DONE cycle is ignored.
- Reset mid-run aborts immediately. Buffered randomness is discarded and no `done` is produced.
- When LAT = RND_CYC, DRAIN is skipped and DONE directly follows the last FEED cycle.

## Configuration

- Macro `GADGET_RND_SEQ_CHECK_EN`.
- Defined: `gadget_done` is compared with the internal schedule every cycle. A mismatch (gadget_done high outside DONE, or low in DONE) sets `err`, which stays at 1 until reset.
- Undefined: `gadget_done` is ignored and `err` is tied to 0.

## Structure

- Shared package `gadget_seq_pkg`: state enum (IDLE, FETCH, FEED, DRAIN, DONE) and the parameter-range limits (`RND_CYC_MAX` = 8, `LAT_MAX` = 63).
- One sub-module, `rnd_buf`: an RND_CYC x RND_W write-indexed buffer with clear-on-read and a full flag.
- Parameter legality is checked with an elaboration-time assertion.

## Test plan

- RND_CYC = 1, LAT = 4, `rnd_in_valid` held at 1, start in cycle 0:
  - `gadget_en` and `active` high in cycle 2 only;
  - `rng_0` equals the word accepted in cycle 1;
  - `done` high in cycle 6.
- RND_CYC = 3, RNG valid only every third cycle:
  - FEED occurs only after the third handshake;
  - `active` is high for 3 consecutive cycles carrying words 0, 1, 2 in order;
  - `done` comes LAT cycles after `gadget_en`.
- `start` pulsed while busy: no second run, exactly one `done`.
- Reset asserted during FEED:
  - all outputs go to 0 asynchronously;
  - the next run's `rng_0` words come only from new handshakes, never from pre-reset words.
- With `GADGET_RND_SEQ_CHECK_EN`:
  - a `gadget_done` pulse one cycle early sets `err` = 1, which persists across later runs until reset;
  - with a correct `gadget_done`, `err` stays 0.
